// File: rtl/bitcell_array_ctrl.sv
// Round-robin, two-requester sequencer for a DEPTH x WIDTH array of NAND SR-latch bit cells.
// Optional macro WRITE_VERIFY_EN adds a read-back verify and response after each write.
module bitcell_array_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 12,
    parameter int PULSE  = 2,
    parameter int SETTLE = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_write,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_write,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [DEPTH-1:0] row_sel,
    output logic [WIDTH-1:0] cell_set_n,
    output logic [WIDTH-1:0] cell_reset_n,
    input  logic [WIDTH-1:0] cell_q,
    output logic             busy
);

    localparam int CMAX = (PULSE > SETTLE) ? PULSE : SETTLE;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, SEL, CLR, GAP1, SET, GAP2, VERIFY, RSP} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             rr_b;
    logic             req_write, req_id;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;

    logic             grant_a, grant_b, accept;
    logic             sel_write, sel_in_range;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             row_en;
    logic             rsp_load, rsp_id_d, rsp_err_d;
    logic [WIDTH-1:0] rsp_data_d;

    // Arbitration only in IDLE; each ready also requires its own valid so at most one is high.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE && !reset) begin
            grant_a = a_valid && (!b_valid || !rr_b);
            grant_b = b_valid && (!a_valid || rr_b);
        end
    end

    assign a_ready      = grant_a;
    assign b_ready      = grant_b;
    assign accept       = grant_a | grant_b;
    assign sel_write    = grant_b ? b_write : a_write;
    assign sel_addr     = grant_b ? b_addr  : a_addr;
    assign sel_wdata    = grant_b ? b_wdata : a_wdata;
    assign sel_in_range = {1'b0, sel_addr} < DEPTH_W;
    assign busy         = (state != IDLE);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        row_en       = 1'b0;
        cell_set_n   = '1;
        cell_reset_n = '1;
        rsp_load     = 1'b0;
        rsp_id_d     = req_id;
        rsp_err_d    = 1'b0;
        rsp_data_d   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next = '0;
                    if (!sel_in_range) begin
                        state_next = RSP;
                        rsp_load   = 1'b1;
                        rsp_err_d  = 1'b1;
                        rsp_id_d   = grant_b;
                    end else begin
                        state_next = sel_write ? CLR : SEL;
                    end
                end
            end
            SEL: begin
                row_en = 1'b1;
                if (cnt == CW'(SETTLE-1)) begin
                    state_next = IDLE;
                    rsp_load   = 1'b1;
                    rsp_data_d = cell_q;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CLR: begin
                row_en       = 1'b1;
                cell_reset_n = '0;
                if (cnt == CW'(PULSE-1)) begin
                    state_next = GAP1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            GAP1: begin
                row_en     = 1'b1;
                state_next = SET;
            end
            SET: begin
                row_en     = 1'b1;
                cell_set_n = ~req_wdata;
                if (cnt == CW'(PULSE-1)) begin
                    state_next = GAP2;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            GAP2: begin
                row_en = 1'b1;
`ifdef WRITE_VERIFY_EN
                state_next = VERIFY;
`else
                state_next = IDLE;
`endif
            end
`ifdef WRITE_VERIFY_EN
            VERIFY: begin
                row_en = 1'b1;
                if (cnt == CW'(SETTLE-1)) begin
                    state_next = RSP;
                    rsp_load   = 1'b1;
                    rsp_data_d = cell_q;
                    rsp_err_d  = (cell_q != req_wdata);
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`endif
            RSP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        row_sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            row_sel[i] = row_en && (req_addr == AW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_b      <= 1'b0;
            req_write <= 1'b0;
            req_id    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            if (accept) begin
                rr_b      <= ~grant_b;
                req_write <= sel_write;
                req_id    <= grant_b;
                req_addr  <= sel_addr;
                req_wdata <= sel_wdata;
            end
            rsp_valid <= rsp_load;
            rsp_id    <= rsp_load & rsp_id_d;
            rsp_err   <= rsp_load & rsp_err_d;
            rsp_rdata <= rsp_load ? rsp_data_d : '0;
        end
    end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Directed bench for bitcell_array_ctrl with a behavioural SR-latch array model.
// Expectations for WRITE_VERIFY_EN builds are selected by the same macro.
module tb_bitcell_array_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_write, b_valid, b_write;
    logic        a_ready, b_ready;
    logic [3:0]  a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic [7:0]  rsp_rdata, cell_set_n, cell_reset_n, cell_q;
    logic [11:0] row_sel;

    int n_cmp = 0;
    int n_bad = 0;
    bit overlap_seen;

    logic [7:0] mem [12];

    bitcell_array_ctrl #(.WIDTH(8), .DEPTH(12), .PULSE(2), .SETTLE(1)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .row_sel(row_sel), .cell_set_n(cell_set_n), .cell_reset_n(cell_reset_n),
        .cell_q(cell_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Latch array model: set_n low forces 1, else reset_n low forces 0.
    always @(posedge clk) begin
        for (int i = 0; i < 12; i++) begin
            if (reset) mem[i] <= 8'h00;
            else if (row_sel[i]) begin
                for (int b = 0; b < 8; b++) begin
                    if (!cell_set_n[b]) mem[i][b] <= 1'b1;
                    else if (!cell_reset_n[b]) mem[i][b] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cell_q = 8'h00;
        for (int i = 0; i < 12; i++) if (row_sel[i]) cell_q = mem[i];
    end

    always @(negedge clk) if (|(~cell_set_n & ~cell_reset_n)) overlap_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         r_busy, r_rsp_n, r_rsp_at, r_clr, r_set;
    logic [7:0] r_rd;
    logic       r_err, r_id;
    logic [11:0] r_rowsel;

    task automatic xact(input bit id, input bit wr, input logic [3:0] addr, input logic [7:0] wd);
        bit done;
        int n;
        @(negedge clk);
        if (!id) begin a_valid = 1; a_write = wr; a_addr = addr; a_wdata = wd; end
        else     begin b_valid = 1; b_write = wr; b_addr = addr; b_wdata = wd; end
        #1;
        chk(id ? "b_ready" : "a_ready", id ? b_ready : a_ready, 1);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0; a_wdata = ~wd; b_wdata = ~wd;
        r_busy = 99; r_rsp_n = 0; r_rsp_at = 0; r_clr = 0; r_set = 0;
        r_rd = 0; r_err = 0; r_id = 0; r_rowsel = 0;
        done = 0; n = 0;
        while (!done && n < 40) begin
            n++;
            @(negedge clk);
            if (rsp_valid) begin
                r_rsp_n++; r_rsp_at = n; r_rd = rsp_rdata; r_err = rsp_err; r_id = rsp_id;
            end
            r_rowsel = r_rowsel | row_sel;
            if (cell_reset_n != 8'hFF) r_clr++;
            if (cell_set_n != 8'hFF) r_set++;
            if (!busy) begin done = 1; r_busy = n - 1; end
        end
    endtask

    task automatic check_write(input string tag, input bit id, input logic [7:0] wd,
                               input logic [11:0] rs, input int set_cyc);
        chk({tag, "_clr_cyc"}, r_clr, 2);
        chk({tag, "_set_cyc"}, r_set, set_cyc);
        chk({tag, "_rowsel"}, r_rowsel, rs);
`ifdef WRITE_VERIFY_EN
        chk({tag, "_busy"}, r_busy, 8);
        chk({tag, "_rsp_n"}, r_rsp_n, 1);
        chk({tag, "_rsp_at"}, r_rsp_at, 8);
        chk({tag, "_rdata"}, r_rd, wd);
        chk({tag, "_err"}, r_err, 0);
        chk({tag, "_id"}, r_id, id);
`else
        chk({tag, "_busy"}, r_busy, 6);
        chk({tag, "_rsp_n"}, r_rsp_n, 0);
`endif
    endtask

    task automatic check_read(input string tag, input bit id, input logic [7:0] rd,
                              input logic [11:0] rs);
        chk({tag, "_busy"}, r_busy, 1);
        chk({tag, "_rsp_n"}, r_rsp_n, 1);
        chk({tag, "_rsp_at"}, r_rsp_at, 2);
        chk({tag, "_rdata"}, r_rd, rd);
        chk({tag, "_err"}, r_err, 0);
        chk({tag, "_id"}, r_id, id);
        chk({tag, "_rowsel"}, r_rowsel, rs);
        chk({tag, "_cells_idle"}, r_clr + r_set, 0);
    endtask

    initial begin
        int na, nb, gi, ri;
        bit seen;
        reset = 1; a_valid = 0; b_valid = 0; a_write = 0; b_write = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;

        // Reset values, and no grant while reset is held
        repeat (2) @(negedge clk);
        a_valid = 1; #1;
        chk("rst_rowsel", row_sel, 0);
        chk("rst_set_n", cell_set_n, 8'hFF);
        chk("rst_reset_n", cell_reset_n, 8'hFF);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_ready", a_ready, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk); #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        a_valid = 0;

        xact(0, 1, 4'd3, 8'hA5);
        check_write("wr_a5", 0, 8'hA5, 12'h008, 2);
        xact(0, 0, 4'd3, 8'h00);
        check_read("rd_a5", 0, 8'hA5, 12'h008);

        xact(1, 0, 4'd13, 8'h00);
        chk("oor_busy", r_busy, 1);
        chk("oor_rsp_n", r_rsp_n, 1);
        chk("oor_rsp_at", r_rsp_at, 1);
        chk("oor_err", r_err, 1);
        chk("oor_rdata", r_rd, 0);
        chk("oor_id", r_id, 1);
        chk("oor_rowsel", r_rowsel, 0);

        // Contending reads: last grant was B, so order is A,B,A,B,...
        @(negedge clk);
        a_valid = 1; a_write = 0; a_addr = 4'd3;
        b_valid = 1; b_write = 0; b_addr = 4'd7;
        na = 0; nb = 0; gi = 0; ri = 0;
        for (int c = 0; c < 60 && ri < 8; c++) begin
            #1;
            if (rsp_valid) begin
                chk("arb_rsp_id", rsp_id, ri % 2);
                chk("arb_rsp_rdata", rsp_rdata, (ri % 2) ? 8'h00 : 8'hA5);
                ri++;
            end
            if (a_ready || b_ready) begin
                chk("arb_exclusive", a_ready & b_ready, 0);
                chk("arb_grant_b", b_ready, gi % 2);
                if (a_ready) na++; else nb++;
                gi++;
            end
            @(posedge clk); #1;
            if (na == 4) a_valid = 0;
            if (nb == 4) b_valid = 0;
            @(negedge clk);
        end
        chk("arb_grants", gi, 8);
        chk("arb_rsps", ri, 8);

        xact(0, 1, 4'd5, 8'hFF);
        check_write("wr_ff", 0, 8'hFF, 12'h020, 2);
        xact(1, 1, 4'd5, 8'h00);
        check_write("wr_00", 1, 8'h00, 12'h020, 0);
        xact(0, 0, 4'd5, 8'h00);
        check_read("rd_00", 0, 8'h00, 12'h020);

        // Reset during the SET pulse of a write
        @(negedge clk);
        a_valid = 1; a_write = 1; a_addr = 4'd0; a_wdata = 8'hFF;
        @(posedge clk); #1;
        a_valid = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cell_set_n != 8'hFF) seen = 1;
        end
        chk("midset_reached", seen, 1);
        reset = 1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rowsel", row_sel, 0);
        chk("midrst_set_n", cell_set_n, 8'hFF);
        chk("midrst_reset_n", cell_reset_n, 8'hFF);
        chk("midrst_rsp_valid", rsp_valid, 0);
        reset = 0;

        xact(0, 1, 4'd0, 8'h3C);
        check_write("wr_3c", 0, 8'h3C, 12'h001, 2);
        xact(0, 0, 4'd0, 8'h00);
        check_read("rd_3c", 0, 8'h3C, 12'h001);

        chk("no_overlap", overlap_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
